// File: rtl/apb_reg_bank_if.sv
// APB3 bus bundle between a master and the apb_reg_bank slave.
// Signal names follow the AMBA APB3 convention.
interface apb_reg_bank_if #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
);
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_reg_bank.sv
// APB3 register bank feeding the ECC core: config registers, start pulse, busy/done/status.
// Optional macro APB_PSLVERR_EN enables PSLVERR responses and rejection of reserved values.
module apb_reg_bank #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    apb_reg_bank_if.slave         apb,
    input  logic                  operation_done,
    input  logic [1:0]            num_of_errors,
    output logic                  start,
    output logic [1:0]            CTRL_op,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic [1:0]            codeword_width,
    output logic [DATA_WIDTH-1:0] noise,
    output logic                  busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} apb_state_e;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_DATA   = 3'd1;
    localparam logic [2:0] A_CW     = 3'd2;
    localparam logic [2:0] A_NOISE  = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    apb_state_e            state_q, state_d;
    logic [AMBA_WORD-1:0]  prdata_q, prdata_d;
    logic                  start_q, start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            errs_q, errs_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic [1:0]            cw_q, cw_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] noise_q, noise_d;

    logic [2:0]           idx;
    logic                 mapped;
    logic                 setup_now;
    logic                 access_now;
    logic                 rsv_val;
    logic                 wr_reject;
    logic [AMBA_WORD-1:0] rd_mux;
    logic                 unused_addr_lsb;

    assign idx             = apb.PADDR[4:2];
    assign mapped          = (apb.PADDR[AMBA_ADDR_WIDTH-1:5] == '0) && (idx <= A_STATUS);
    assign unused_addr_lsb = ^apb.PADDR[1:0];

    // state_q holds the phase of the previous cycle, so ACCESS is only honoured right after SETUP.
    assign setup_now  = apb.PSEL && !apb.PENABLE;
    assign access_now = apb.PSEL && apb.PENABLE && (state_q == ST_SETUP);

`ifdef APB_PSLVERR_EN
    assign rsv_val     = (apb.PWDATA[1:0] == 2'd3) && ((idx == A_CTRL) || (idx == A_CW));
    assign apb.PSLVERR = access_now && (apb.PWRITE ? wr_reject : !mapped);
`else
    assign rsv_val     = 1'b0;
    assign apb.PSLVERR = 1'b0;
`endif

    assign wr_reject = !mapped || (idx == A_STATUS) || ((idx == A_CTRL) && busy_q) || rsv_val;

    always_comb begin
        rd_mux = '0;
        if (mapped) begin
            case (idx)
                A_CTRL:   rd_mux = AMBA_WORD'(ctrl_q);
                A_DATA:   rd_mux = AMBA_WORD'(data_q);
                A_CW:     rd_mux = AMBA_WORD'(cw_q);
                A_NOISE:  rd_mux = AMBA_WORD'(noise_q);
                A_STATUS: rd_mux = AMBA_WORD'({errs_q, done_q, busy_q});
                default:  rd_mux = '0;
            endcase
        end
    end

    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path infers a latch.
        state_d  = setup_now ? ST_SETUP : (access_now ? ST_ACCESS : ST_IDLE);
        prdata_d = (setup_now && !apb.PWRITE) ? rd_mux : prdata_q;
        start_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
        errs_d   = errs_q;
        ctrl_d   = ctrl_q;
        cw_d     = cw_q;
        data_d   = data_q;
        noise_d  = noise_q;

        if (access_now && apb.PWRITE && !wr_reject) begin
            case (idx)
                A_CTRL: begin
                    ctrl_d  = apb.PWDATA[1:0];
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                end
                A_DATA:  data_d  = DATA_WIDTH'(apb.PWDATA);
                A_CW:    cw_d    = apb.PWDATA[1:0];
                A_NOISE: noise_d = DATA_WIDTH'(apb.PWDATA);
                default: ;
            endcase
        end

        // A CTRL launch needs !busy_q, so it can never collide with completion handling here.
        if (operation_done && busy_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            errs_d = num_of_errors;
        end else if (access_now && !apb.PWRITE && mapped && (idx == A_STATUS)) begin
            done_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all of it clears asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            prdata_q <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            errs_q   <= '0;
            ctrl_q   <= '0;
            cw_q     <= '0;
            data_q   <= '0;
            noise_q  <= '0;
        end else begin
            state_q  <= state_d;
            prdata_q <= prdata_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            errs_q   <= errs_d;
            ctrl_q   <= ctrl_d;
            cw_q     <= cw_d;
            data_q   <= data_d;
            noise_q  <= noise_d;
        end
    end

    assign apb.PRDATA    = prdata_q;
    assign apb.PREADY    = 1'b1;
    assign start         = start_q;
    assign busy          = busy_q;
    assign CTRL_op       = ctrl_q;
    assign codeword_width = cw_q;
    assign data_in       = data_q;
    assign noise         = noise_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank: register access, start/busy/done handshake, lockout, collision, reset.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge or #1 after a rising edge.
module tb_apb_reg_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        operation_done = 1'b0;
    logic [1:0]  num_of_errors = 2'd0;
    logic        start;
    logic [1:0]  CTRL_op;
    logic [31:0] data_in;
    logic [1:0]  codeword_width;
    logic [31:0] noise;
    logic        busy;
    logic [31:0] rd;

    int n_checks = 0;
    int n_pass   = 0;

    apb_reg_bank_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) apb ();

    apb_reg_bank #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .apb            (apb),
        .operation_done (operation_done),
        .num_of_errors  (num_of_errors),
        .start          (start),
        .CTRL_op        (CTRL_op),
        .data_in        (data_in),
        .codeword_width (codeword_width),
        .noise          (noise),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic bus_idle();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
    endtask

    // Returns #1 after the commit edge.
    task automatic apb_write(input logic [19:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = addr; apb.PWDATA = data;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic apb_read(input logic [19:0] addr, output logic [31:0] data);
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = addr;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(negedge clk);
        data = apb.PRDATA;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic pulse_done(input logic [1:0] errs);
        @(posedge clk); #1;
        operation_done = 1'b1; num_of_errors = errs;
        @(posedge clk); #1;
        operation_done = 1'b0; num_of_errors = 2'd0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_idle();
        #2;
        check("rst_prdata", apb.PRDATA, 32'h0);
        check("rst_pready", 32'(apb.PREADY), 32'h1);
        check("rst_busy",   32'(busy), 32'h0);
        check("rst_start",  32'(start), 32'h0);
        #10 rst = 1'b1;

        // Write/readback
        apb_write(20'h04, 32'hA5A5_A5A5);
        apb_write(20'h08, 32'h2);
        apb_write(20'h0C, 32'h1234_5678);
        apb_read(20'h04, rd); check("rd_data", rd, 32'hA5A5_A5A5);
        apb_read(20'h08, rd); check("rd_cw",   rd, 32'h2);
        apb_read(20'h0C, rd); check("rd_noise", rd, 32'h1234_5678);
        check("data_in", data_in, 32'hA5A5_A5A5);
        check("cw_out",  32'(codeword_width), 32'h2);

        // PENABLE without SETUP must be ignored
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PWRITE = 1'b1;
        apb.PADDR = 20'h0C; apb.PWDATA = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus_idle();
        check("orphan_enable", noise, 32'h1234_5678);

        // Start
        apb_write(20'h00, 32'h2);
        check("start_hi",  32'(start), 32'h1);
        check("busy_hi",   32'(busy), 32'h1);
        check("ctrl_op2",  32'(CTRL_op), 32'h2);
        @(posedge clk); #1;
        check("start_1cyc", 32'(start), 32'h0);
        check("busy_held",  32'(busy), 32'h1);

        // Busy lockout
        apb_write(20'h00, 32'h1);
        check("lock_start", 32'(start), 32'h0);
        check("lock_ctrl",  32'(CTRL_op), 32'h2);
        apb_write(20'h04, 32'h0000_00FF);
        check("busy_data_wr", data_in, 32'h0000_00FF);

        // Completion and sticky done
        pulse_done(2'd1);
        check("done_busy", 32'(busy), 32'h0);
        apb_read(20'h10, rd); check("status1", rd, 32'h6);
        apb_read(20'h10, rd); check("status2", rd, 32'h4);

        // operation_done while idle is ignored
        pulse_done(2'd3);
        apb_read(20'h10, rd); check("idle_done", rd, 32'h4);

        // Collision: CTRL commit on the same edge as operation_done
        apb_write(20'h00, 32'h1);
        check("ctrl_op1", 32'(CTRL_op), 32'h1);
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = 20'h00; apb.PWDATA = 32'h2;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1; operation_done = 1'b1; num_of_errors = 2'd2;
        @(posedge clk); #1;
        bus_idle(); operation_done = 1'b0; num_of_errors = 2'd0;
        check("coll_ctrl",  32'(CTRL_op), 32'h1);
        check("coll_busy",  32'(busy), 32'h0);
        check("coll_start", 32'(start), 32'h0);
        @(posedge clk); #1;
        check("coll_start2", 32'(start), 32'h0);
        apb_read(20'h10, rd); check("coll_status", rd, 32'hA);

        // Unmapped and aliased addresses
        apb_write(20'h20, 32'hFFFF_FFFF);
        check("unm_data",  data_in, 32'h0000_00FF);
        check("unm_noise", noise, 32'h1234_5678);
        check("unm_cw",    32'(codeword_width), 32'h2);
        check("unm_ctrl",  32'(CTRL_op), 32'h1);
        apb_read(20'h20, rd);    check("unm_read", rd, 32'h0);
        apb_read(20'h8_0004, rd); check("alias_read", rd, 32'h0);
        check("pslverr_off", 32'(apb.PSLVERR), 32'h0);

        // Asynchronous reset mid-operation
        apb_write(20'h00, 32'h3);
        check("pre_rst_busy", 32'(busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy",  32'(busy), 32'h0);
        check("arst_start", 32'(start), 32'h0);
        check("arst_ctrl",  32'(CTRL_op), 32'h0);
        check("arst_data",  data_in, 32'h0);
        check("arst_noise", noise, 32'h0);
        check("arst_cw",    32'(codeword_width), 32'h0);
        check("arst_prd",   apb.PRDATA, 32'h0);
        check("arst_ready", 32'(apb.PREADY), 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        apb_read(20'h10, rd); check("arst_status", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
